ad9288_capture_buffer: RTL and testbench
========================================

// Module: ad9288_capture_buffer
// PURPOSE
//  Upstream acquisition stage for AD9288 channel samples: decimates the raw 8-bit ADC bus, waits for a level/slope
//  trigger, then records DEPTH samples into on-chip RAM. Exposes control/status/data registers on an Avalon-MM
//  slave (32-bit, 2-bit word address) so the HPS oscilloscope software pops captured samples one read at a time.
// PARAMETERS
//  DEPTH      1024   samples per capture; power of two, 16..4096
//  DECIM_W    16     width of decimation divisor register
//  TIMEOUT    2**20  auto-trigger timeout in clk cycles (used only with AD9288_CAP_AUTO_TRIG_EN)
// PORTS
//  clk        in   1   system/sample clock; adc_data is synchronous to it
//  reset_n    in   1   asynchronous, active-low reset
//  adc_data   in   8   raw AD9288 sample, offset binary
//  address    in   2   Avalon word address: 0 CTRL, 1 STATUS, 2 DATA, 3 DECIM
//  read       in   1   Avalon read strobe
//  write      in   1   Avalon write strobe
//  writedata  in   32  Avalon write data
//  readdata   out  32  Avalon read data, registered
//  irq        out  1   high while state==DONE and IRQ enable set
// BEHAVIOUR
//  Reset: state IDLE, readdata 0, irq 0, level 0x80, slope rising, decim 0, irq_en 0, pointers 0, prev_valid 0.
//  Registers:
//   CTRL  W: [0] arm, [1] abort, [8] slope (0 rise, 1 fall), [9] irq_en, [23:16] level. R: same fields, [1:0]=0.
//   STATUS R: [0] armed, [1] capturing, [2] done, [3] timeout-triggered, [15+:] samples remaining to read.
//   DATA  R: [31] valid, [7:0] sample; pops one sample only in DONE; outside DONE returns 0, no pop.
//   DECIM R/W: [DECIM_W-1:0] divisor d; a sample is taken every d+1 clks (d=0 -> every clk).
//  Read latency: 1 clk; readdata registered from address mux every cycle; pop side-effect on read&&address==2.
//  Decimator: counter reloads to d on each sample tick; new DECIM write takes effect at next reload.
//  FSM:
//   IDLE    -> ARMED on CTRL write arm=1; clears prev_valid, write pointer, decim counter.
//   ARMED   on each tick: trig = prev_valid && (rise ? prev<level && cur>=level : prev>level && cur<=level);
//           trig -> CAPTURE, triggering sample stored as sample 0; prev updated every tick.
//   CAPTURE store each tick at wr_ptr; after sample DEPTH-1 written -> DONE, rd_ptr=0.
//   DONE    each DATA pop returns RAM[rd_ptr], rd_ptr++; pop of sample DEPTH-1 -> IDLE (valid=1 on that word).
//  Abort (CTRL[1]) from any state -> IDLE next clk; abort wins over arm in the same write.
//  Arm while ARMED/CAPTURE ignored; arm in DONE discards unread data and restarts (-> ARMED).
//  CTRL writes of level/slope during ARMED take effect on the next tick.
//  RAM: simple dual-port, DEPTH x 8, 1-clk read; next sample prefetched so back-to-back pops are valid.
//  Comparisons unsigned 8-bit; pointers are log2(DEPTH) bits, no wrap during capture.
//  Reset mid-capture: all state to reset values; RAM contents undefined, never returned (valid=0).
// CONFIGURATION
//  AD9288_CAP_AUTO_TRIG_EN defined: in ARMED a counter runs from arm; reaching TIMEOUT clks with no trigger forces
//   CAPTURE starting at the next tick and sets STATUS[3] (cleared on next arm).
//  Not defined: ARMED waits indefinitely; STATUS[3] reads 0; no timeout counter synthesized.
// TESTING
//  1 reset -> readdata 0, STATUS 0, CTRL reads level 0x80; DATA read returns 0x0000_0000.
//  2 DEPTH=16, d=0, level 0x80 rise, ramp 0x70..0x8F after arm -> capture begins at 0x80; 16 pops return
//    0x80000080..0x8000008F, then STATUS.done=0, state IDLE.
//  3 falling slope, d=3, square wave 0xF0/0x10 -> capture starts on first 0x10 after a 0xF0; samples spaced 4 clks.
//  4 abort and arm in one write during CAPTURE -> IDLE, STATUS=0; arm in DONE after 5 pops -> ARMED, remaining=DEPTH.
//  5 constant 0x40 with AD9288_CAP_AUTO_TRIG_EN, TIMEOUT=100 -> DONE with STATUS[3]=1; without macro -> stays ARMED.
//  6 assert reset_n mid-CAPTURE -> all outputs 0 immediately; subsequent DATA read returns 0x0000_0000.

Source files
------------

// File: rtl/ad9288_capture_buffer.sv
// ad9288_capture_buffer
//   Decimates the raw AD9288 8-bit sample bus, waits for a level/slope trigger,
//   records DEPTH samples into on-chip RAM and hands them to software one
//   Avalon-MM DATA read at a time.
//   Build option: define AD9288_CAP_AUTO_TRIG_EN to add the auto-trigger timeout
//   (forces a capture TIMEOUT clks after arm, flagged in STATUS[3]).
module ad9288_capture_buffer #(
   parameter int unsigned DEPTH   = 1024,
   parameter int unsigned DECIM_W = 16,
   parameter int unsigned TIMEOUT = 2**20
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [7:0]  adc_data,
   input  logic [1:0]  address,
   input  logic        read,
   input  logic        write,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        irq
);

   localparam int unsigned AW = $clog2(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [7:0]          level_q, level_d;
   logic                slope_q, slope_d;
   logic                irq_en_q, irq_en_d;
   logic [DECIM_W-1:0]  decim_q, decim_d;
   logic [DECIM_W-1:0]  dcnt_q, dcnt_d;
   logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [AW:0]         rem_q, rem_d;
   logic [7:0]          prev_q, prev_d;
   logic                prev_valid_q, prev_valid_d;
   logic                to_flag_q, to_flag_d;
   logic [31:0]         readdata_q, readdata_d;
   logic                irq_q, irq_d;

   logic [7:0]          mem [DEPTH];
   logic [7:0]          ram_rd_q;
   logic                ram_we;

   logic                ctrl_wr, abort, arm, pop, tick, level_hit, trig;
   logic                unused_bits;

`ifdef AD9288_CAP_AUTO_TRIG_EN
   localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
   logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
   assign unused_bits = ^writedata[31:24];
`else
   assign unused_bits = ^{writedata[31:24], TIMEOUT[0]};
`endif

   // Next-state: register writes, decimator, trigger/capture/readout FSM, read mux
   always_comb begin
      state_d      = state_q;
      level_d      = level_q;
      slope_d      = slope_q;
      irq_en_d     = irq_en_q;
      decim_d      = decim_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      rem_d        = rem_q;
      prev_d       = prev_q;
      prev_valid_d = prev_valid_q;
      ram_we       = 1'b0;

      ctrl_wr = write && (address == 2'd0);
      abort   = ctrl_wr && writedata[1];
      arm     = ctrl_wr && writedata[0] && !writedata[1];
      pop     = read && (address == 2'd2) && (state_q == S_DONE);

      tick   = (dcnt_q == '0);
      dcnt_d = tick ? decim_q : dcnt_q - 1'b1;

      level_hit = prev_valid_q &&
                  (slope_q ? (prev_q > level_q && adc_data <= level_q)
                           : (prev_q < level_q && adc_data >= level_q));

`ifdef AD9288_CAP_AUTO_TRIG_EN
      to_cnt_d  = to_cnt_q;
      to_flag_d = to_flag_q;
      if (state_q == S_ARMED && !to_flag_q) begin
         if (to_cnt_q == TO_W'(TIMEOUT - 1)) to_flag_d = 1'b1;
         else                                to_cnt_d  = to_cnt_q + 1'b1;
      end
      trig = level_hit || to_flag_q;
`else
      to_flag_d = 1'b0;
      trig      = level_hit;
`endif

      // Field updates land in the registers; the current tick still uses old values.
      if (ctrl_wr) begin
         slope_d  = writedata[8];
         irq_en_d = writedata[9];
         level_d  = writedata[23:16];
      end
      if (write && address == 2'd3) decim_d = writedata[DECIM_W-1:0];

      if (abort) begin
         state_d = S_IDLE;
         rem_d   = '0;
      end else if (arm && (state_q == S_IDLE || state_q == S_DONE)) begin
         state_d      = S_ARMED;
         wr_ptr_d     = '0;
         rd_ptr_d     = '0;
         prev_valid_d = 1'b0;
         dcnt_d       = '0;
         rem_d        = (AW+1)'(DEPTH);
         to_flag_d    = 1'b0;
`ifdef AD9288_CAP_AUTO_TRIG_EN
         to_cnt_d     = '0;
`endif
      end else begin
         case (state_q)
            S_ARMED: if (tick) begin
               prev_d       = adc_data;
               prev_valid_d = 1'b1;
               if (trig) begin
                  ram_we   = 1'b1;
                  wr_ptr_d = wr_ptr_q + 1'b1;
                  state_d  = S_CAPTURE;
               end
            end
            S_CAPTURE: if (tick) begin
               ram_we   = 1'b1;
               wr_ptr_d = wr_ptr_q + 1'b1;
               if (&wr_ptr_q) begin
                  state_d  = S_DONE;
                  rd_ptr_d = '0;
               end
            end
            S_DONE: if (pop) begin
               rd_ptr_d = rd_ptr_q + 1'b1;
               rem_d    = rem_q - 1'b1;
               if (&rd_ptr_q) state_d = S_IDLE;
            end
            default: ;
         endcase
      end

      readdata_d = '0;
      case (address)
         2'd0: readdata_d = {8'h00, level_q, 6'h00, irq_en_q, slope_q, 8'h00};
         2'd1: begin
            readdata_d[15 +: AW+1] = rem_q;
            readdata_d[3:0] = {to_flag_q, state_q == S_DONE,
                               state_q == S_CAPTURE, state_q == S_ARMED};
         end
         2'd2: if (state_q == S_DONE) readdata_d = {1'b1, 23'h0, ram_rd_q};
         default: readdata_d = 32'(decim_q);
      endcase

      irq_d = (state_d == S_DONE) && irq_en_d;
   end

   // Control/status registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         level_q      <= 8'h80;
         slope_q      <= 1'b0;
         irq_en_q     <= 1'b0;
         decim_q      <= '0;
         dcnt_q       <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         rem_q        <= '0;
         prev_q       <= '0;
         prev_valid_q <= 1'b0;
         to_flag_q    <= 1'b0;
         readdata_q   <= '0;
         irq_q        <= 1'b0;
`ifdef AD9288_CAP_AUTO_TRIG_EN
         to_cnt_q     <= '0;
`endif
      end else begin
         state_q      <= state_d;
         level_q      <= level_d;
         slope_q      <= slope_d;
         irq_en_q     <= irq_en_d;
         decim_q      <= decim_d;
         dcnt_q       <= dcnt_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         rem_q        <= rem_d;
         prev_q       <= prev_d;
         prev_valid_q <= prev_valid_d;
         to_flag_q    <= to_flag_d;
         readdata_q   <= readdata_d;
         irq_q        <= irq_d;
`ifdef AD9288_CAP_AUTO_TRIG_EN
         to_cnt_q     <= to_cnt_d;
`endif
      end
   end

   // Sample RAM; read port follows the next read pointer so the word for the
   // following pop is already prefetched when the current pop completes
   always_ff @(posedge clk) begin
      if (ram_we) mem[wr_ptr_q] <= adc_data;
      ram_rd_q <= mem[rd_ptr_d];
   end

   assign readdata = readdata_q;
   assign irq      = irq_q;

endmodule

// File: tb/tb_ad9288_capture_buffer.sv
// tb_ad9288_capture_buffer
//   Reference model of the capture buffer kept as a sample queue plus pop count,
//   compared against readdata/irq on every clock, with literal expectations for
//   reset values, ramp capture, falling-slope capture, abort/re-arm and reset.
module tb_ad9288_capture_buffer;

   localparam int unsigned DEPTH   = 16;
   localparam int unsigned TIMEOUT = 100;
   localparam int IDLE = 0, ARMED = 1, CAPTURE = 2, DONE = 3;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [7:0]  adc_data = 8'h00;
   logic [1:0]  address = 2'd0;
   logic        read = 1'b0;
   logic        write = 1'b0;
   logic [31:0] writedata = '0;
   logic [31:0] readdata;
   logic        irq;

   ad9288_capture_buffer #(.DEPTH(DEPTH), .DECIM_W(16), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset_n(reset_n), .adc_data(adc_data), .address(address),
      .read(read), .write(write), .writedata(writedata),
      .readdata(readdata), .irq(irq)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- ADC stimulus (changes 2 time units after posedge) -------
   int         adc_mode = 0;   // 0 const 0x40, 1 ramp from 0x70, 2 square F0/10, 3 random
   int         last_mode = 0;
   logic [7:0] ramp_val = 8'h70;
   int         sq_cnt = 0;
   logic       sq_hi = 1'b1;

   always @(posedge clk) begin
      #2;
      if (adc_mode == 1 && last_mode != 1) ramp_val = 8'h70;
      case (adc_mode)
         0: adc_data = 8'h40;
         1: begin adc_data = ramp_val; ramp_val = ramp_val + 8'd1; end
         2: begin
            sq_cnt++;
            if (sq_cnt == 6) begin sq_cnt = 0; sq_hi = !sq_hi; end
            adc_data = sq_hi ? 8'hF0 : 8'h10;
         end
         default: adc_data = 8'($urandom);
      endcase
      last_mode = adc_mode;
   end

   // ---------------- Reference model ----------------------------------------
   int          m_st, m_phase, m_acnt, m_pops;
   logic [7:0]  m_level, m_prev;
   logic        m_slope, m_irqen, m_toflag, m_pv;
   logic [15:0] m_decim;
   logic [7:0]  m_buf[$];
   logic [31:0] exp_rd = '0;
   logic        exp_irq = 1'b0;

   always @(posedge clk) begin : model
      logic        ctrl_wr, do_abort, do_arm, tick, hit;
      logic [31:0] rd;
      int          rem;
      if (!reset_n) begin
         m_st = IDLE; m_phase = 0; m_acnt = 0; m_pops = 0;
         m_level = 8'h80; m_prev = 8'h00; m_slope = 1'b0; m_irqen = 1'b0;
         m_toflag = 1'b0; m_pv = 1'b0; m_decim = 16'h0; m_buf.delete();
         exp_rd = '0; exp_irq = 1'b0;
      end else begin
         ctrl_wr  = write && address == 2'd0;
         do_abort = ctrl_wr && writedata[1];
         do_arm   = ctrl_wr && writedata[0] && !writedata[1];
         tick     = (m_st == ARMED || m_st == CAPTURE) && (m_phase % (int'(m_decim) + 1) == 0);
         hit      = m_pv && (m_slope ? (m_prev > m_level && adc_data <= m_level)
                                     : (m_prev < m_level && adc_data >= m_level));
`ifdef AD9288_CAP_AUTO_TRIG_EN
         hit = hit || m_toflag;
`endif
         rem = (m_st == IDLE) ? 0 : int'(DEPTH) - m_pops;
         case (address)
            2'd0: rd = {8'h00, m_level, 6'h00, m_irqen, m_slope, 8'h00};
            2'd1: rd = (32'(rem) << 15) |
                       32'({m_toflag, m_st == DONE, m_st == CAPTURE, m_st == ARMED});
            2'd2: rd = (m_st == DONE) ? {1'b1, 23'h0, m_buf[m_pops]} : 32'h0;
            default: rd = 32'(m_decim);
         endcase

         if (m_st == ARMED || m_st == CAPTURE) m_phase++;
`ifdef AD9288_CAP_AUTO_TRIG_EN
         if (m_st == ARMED && !m_toflag) begin
            m_acnt++;
            if (m_acnt == int'(TIMEOUT)) m_toflag = 1'b1;
         end
`endif
         if (ctrl_wr) begin
            m_slope = writedata[8]; m_irqen = writedata[9]; m_level = writedata[23:16];
         end
         if (write && address == 2'd3) m_decim = writedata[15:0];

         if (do_abort) m_st = IDLE;
         else if (do_arm && (m_st == IDLE || m_st == DONE)) begin
            m_st = ARMED; m_phase = 0; m_pv = 1'b0; m_buf.delete(); m_pops = 0;
            m_toflag = 1'b0; m_acnt = 0;
         end else if (m_st == ARMED && tick) begin
            m_prev = adc_data; m_pv = 1'b1;
            if (hit) begin m_buf.push_back(adc_data); m_st = CAPTURE; end
         end else if (m_st == CAPTURE && tick) begin
            m_buf.push_back(adc_data);
            if (m_buf.size() == DEPTH) m_st = DONE;
         end else if (m_st == DONE && read && address == 2'd2) begin
            m_pops++;
            if (m_pops == int'(DEPTH)) m_st = IDLE;
         end
         exp_rd  = rd;
         exp_irq = (m_st == DONE) && m_irqen;
      end
   end

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      if (reset_n) begin
         check("readdata", readdata, exp_rd);
         check("irq", 32'(irq), 32'(exp_irq));
      end
   end

   // ---------------- Bus tasks ----------------------------------------------
   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk); address = a; writedata = d; write = 1'b1;
      @(negedge clk); write = 1'b0;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
      @(negedge clk); address = a; read = 1'b1;
      @(negedge clk); read = 1'b0; d = readdata;
   endtask

   task automatic wait_status(input string name, input logic [31:0] mask, input int budget);
      logic [31:0] s;
      bit ok;
      ok = 1'b0;
      s  = '0;
      for (int i = 0; i < budget && !ok; i++) begin
         bus_read(2'd1, s);
         if ((s & mask) != 0) ok = 1'b1;
      end
      if (!ok) begin
         n_checks++; n_err++;
         $display("FAIL %s: STATUS mask 0x%08h never set, last 0x%08h", name, mask, s);
      end
   endtask

   task automatic restart_ramp();
      adc_mode = 0;
      @(negedge clk); @(negedge clk);
      adc_mode = 1;
   endtask

   // ---------------- Directed + random sequence ------------------------------
   initial begin
      logic [31:0] s;
      logic [7:0]  lvl;
      logic        sl, ie;
      int          d;

      repeat (3) @(negedge clk);
      #2 reset_n = 1'b1;

      // reset values
      check("reset_readdata", readdata, 32'h0);
      bus_read(2'd0, s); check("reset_ctrl", s, 32'h0080_0000);
      bus_read(2'd1, s); check("reset_status", s, 32'h0);
      bus_read(2'd2, s); check("reset_data", s, 32'h0);
      bus_read(2'd3, s); check("reset_decim", s, 32'h0);

      // rising ramp capture, d=0, irq enabled
      bus_write(2'd3, 32'd0);
      restart_ramp();
      bus_write(2'd0, 32'h0080_0201);
      wait_status("ramp_done", 32'h4, 60);
      check("ramp_irq_high", 32'(irq), 32'h1);
      for (int i = 0; i < int'(DEPTH); i++) begin
         bus_read(2'd2, s);
         check("ramp_pop", s, 32'h8000_0080 + 32'(i));
      end
      bus_read(2'd1, s); check("ramp_status_after", s, 32'h0);
      check("ramp_irq_low", 32'(irq), 32'h0);

      // falling slope, d=3, square wave
      adc_mode = 2;
      bus_write(2'd3, 32'd3);
      bus_write(2'd0, 32'h0080_0101);
      wait_status("square_done", 32'h4, 200);
      bus_read(2'd2, s); check("square_first", s, 32'h8000_0010);
      for (int i = 1; i < int'(DEPTH); i++) bus_read(2'd2, s);
      bus_read(2'd1, s); check("square_status_after", s, 32'h0);

      // abort+arm in one write during CAPTURE; then arm in DONE
      bus_write(2'd3, 32'd0);
      restart_ramp();
      bus_write(2'd0, 32'h0080_0001);
      wait_status("abort_capturing", 32'h2, 20);
      bus_write(2'd0, 32'h0080_0003);
      bus_read(2'd1, s); check("abort_status", s, 32'h0);
      restart_ramp();
      bus_write(2'd0, 32'h0080_0001);
      wait_status("rearm_done", 32'h4, 60);
      for (int i = 0; i < 5; i++) begin
         bus_read(2'd2, s);
         check("rearm_pop", s, 32'h8000_0080 + 32'(i));
      end
      bus_read(2'd1, s); check("done_remaining", s, ((DEPTH - 5) << 15) | 32'h4);
      adc_mode = 0;
      bus_write(2'd0, 32'h0080_0001);
      bus_read(2'd1, s); check("rearm_status", s, 32'h0008_0001);

      // constant input: timeout behaviour
`ifdef AD9288_CAP_AUTO_TRIG_EN
      wait_status("timeout_done", 32'h4, 200);
      bus_read(2'd1, s); check("timeout_status", s, 32'h0008_000C);
`else
      repeat (300) @(negedge clk);
      bus_read(2'd1, s); check("no_timeout_status", s, 32'h0008_0001);
`endif
      bus_write(2'd0, 32'h0080_0002);
      bus_read(2'd1, s); check("abort_idle_status", s & 32'hFFFF_FFF7, 32'h0);

      // randomized captures
      for (int r = 0; r < 4; r++) begin
         lvl = 8'($urandom_range(8'h20, 8'hE0));
         sl  = 1'($urandom_range(0, 1));
         ie  = 1'($urandom_range(0, 1));
         d   = int'($urandom_range(0, 3));
         adc_mode = 3;
         bus_write(2'd3, 32'(d));
         bus_write(2'd0, {8'h00, lvl, 6'h00, ie, sl, 8'h01});
         wait_status("rand_done", 32'h4, 1500);
         for (int i = 0; i < int'(DEPTH); i++) begin
            if ($urandom_range(0, 2) == 0) bus_read(2'($urandom_range(0, 1)), s);
            bus_read(2'd2, s);
         end
         bus_read(2'd1, s); check("rand_status_after", s & 32'hFFFF_FFF7, 32'h0);
      end

      // reset mid-capture
      bus_write(2'd3, 32'd0);
      restart_ramp();
      bus_write(2'd0, 32'h0080_0201);
      wait_status("reset_capturing", 32'h2, 20);
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("midreset_readdata", readdata, 32'h0);
      check("midreset_irq", 32'(irq), 32'h0);
      repeat (2) @(negedge clk);
      #2 reset_n = 1'b1;
      bus_read(2'd2, s); check("postreset_data", s, 32'h0);
      bus_read(2'd1, s); check("postreset_status", s, 32'h0);
      bus_read(2'd0, s); check("postreset_ctrl", s, 32'h0080_0000);

      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
